// File: rtl/gfx_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gfx_bus_pkg                                                                |
// | Shared graphics register bus constants: register map, chipselect, states.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package gfx_bus_pkg;

    localparam logic [3:0] GFX_PAD1_X     = 4'd0;
    localparam logic [3:0] GFX_PAD1_Y     = 4'd1;
    localparam logic [3:0] GFX_PAD2_X     = 4'd2;
    localparam logic [3:0] GFX_PAD2_Y     = 4'd3;
    localparam logic [3:0] GFX_BALL_X     = 4'd4;
    localparam logic [3:0] GFX_BALL_Y     = 4'd5;
    localparam logic [3:0] GFX_BALL_Z     = 4'd6;
    localparam logic [3:0] GFX_P1_SCORE   = 4'd7;
    localparam logic [3:0] GFX_P2_SCORE   = 4'd8;
    localparam logic [3:0] GFX_GAME_STATE = 4'd9;
    localparam logic [3:0] GFX_COMMIT     = 4'hF;

    localparam logic [3:0] CS_GFX = 4'b0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } gfx_state_t;

endpackage

`default_nettype wire

// File: rtl/gfx_dirty_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gfx_dirty_pick                                                             |
// | Combinational lowest-set-bit encoder over the dirty-register mask.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gfx_dirty_pick #(
    parameter int N     = 10,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     i_mask,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan from the top so the lowest set bit is the last one to win.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = IDX_W'(i);
                o_any = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/gfx_reg_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gfx_reg_writer                                                             |
// | Writes changed game-object registers to the graphics ASIC, then COMMIT.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gfx_reg_writer #(
    parameter int         NUM_REGS    = 10,
    parameter int         HOLD_CYCLES = 2,
    parameter logic [3:0] CS_GFX      = gfx_bus_pkg::CS_GFX,
    parameter logic [3:0] COMMIT_ADDR = gfx_bus_pkg::GFX_COMMIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  upd_valid,
    input  logic [16*NUM_REGS-1:0] upd_data,
    output logic                  upd_ready,
    output logic [3:0]            chipselect,
    output logic [3:0]            data_address,
    output logic [15:0]           databus,
    output logic                  busy,
    output logic                  done
);
    import gfx_bus_pkg::*;

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_HOLD    = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    gfx_state_t                        r_state;
    logic [NUM_REGS-1:0][15:0]         r_snap;
    logic [NUM_REGS-1:0][15:0]         r_last;
    logic [NUM_REGS-1:0]               r_mask;
    logic                              r_sent_valid;
    logic [IDX_W-1:0]                  r_cur;
    logic                              r_is_commit;
    logic [CNT_W-1:0]                  r_cnt;
    logic [3:0]                        r_cs;
    logic [3:0]                        r_addr;
    logic [15:0]                       r_data;
    logic                              r_ready;
    logic                              r_busy;
    logic                              r_done;

    logic [NUM_REGS-1:0][15:0]         w_upd_regs;
    logic [NUM_REGS-1:0][15:0]         w_src;
    logic [NUM_REGS-1:0]               w_new_dirty;
    logic [NUM_REGS-1:0]               w_cur_hot;
    logic [NUM_REGS-1:0]               w_gap_mask;
    logic [NUM_REGS-1:0]               w_pick_in;
    logic [IDX_W-1:0]                  w_idx;
    logic                              w_any;
    logic [3:0]                        w_next_addr;
    logic [15:0]                       w_next_data;

    assign w_upd_regs = upd_data;

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_cmp
            assign w_new_dirty[i] = !r_sent_valid || (w_upd_regs[i] != r_last[i]);
            assign w_cur_hot[i]   = (r_cur == IDX_W'(i));
        end
    endgenerate

    // In GAP the picker looks at what is left after retiring the current
    // register; otherwise it looks at the mask of the incoming snapshot.
    assign w_gap_mask = r_mask & ~w_cur_hot;
    assign w_pick_in  = (r_state == GAP) ? w_gap_mask : w_new_dirty;
    assign w_src      = (r_state == GAP) ? r_snap : w_upd_regs;

    gfx_dirty_pick #(
        .N     (NUM_REGS),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_mask (w_pick_in),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    assign w_next_addr = w_any ? 4'(w_idx) : COMMIT_ADDR;
    assign w_next_data = w_any ? w_src[w_idx] : 16'h0000;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_mask       <= '0;
            r_sent_valid <= 1'b0;
            r_cur        <= '0;
            r_is_commit  <= 1'b0;
            r_cnt        <= '0;
            r_cs         <= 4'b0000;
            r_addr       <= 4'h0;
            r_data       <= 16'h0000;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                    if (upd_valid) begin
                        r_snap      <= w_upd_regs;
                        r_mask      <= w_new_dirty;
                        r_busy      <= 1'b1;
                        r_ready     <= 1'b0;
                        r_state     <= HOLD;
                        r_cnt       <= c_CNT_ONE;
                        r_cs        <= CS_GFX;
                        r_cur       <= w_idx;
                        r_is_commit <= !w_any;
                        r_addr      <= w_next_addr;
                        r_data      <= w_next_data;
                    end
                end
                HOLD: begin
                    if (r_cnt == c_HOLD) begin
                        r_cs    <= 4'b0000;
                        r_state <= GAP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                GAP: begin
                    if (r_is_commit) begin
                        r_state      <= DONE;
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_ready      <= 1'b1;
                        r_sent_valid <= 1'b1;
                    end else begin
                        r_last[r_cur] <= r_snap[r_cur];
                        r_mask        <= w_gap_mask;
                        r_state       <= HOLD;
                        r_cnt         <= c_CNT_ONE;
                        r_cs          <= CS_GFX;
                        r_cur         <= w_idx;
                        r_is_commit   <= !w_any;
                        r_addr        <= w_next_addr;
                        r_data        <= w_next_data;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign upd_ready    = r_ready;
    assign chipselect   = r_cs;
    assign data_address = r_addr;
    assign databus      = r_data;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

`default_nettype wire
